// File: rtl/iq_pkg.sv
// Shared definitions for the issue-queue select/broadcast slice.
//   IQ_DEPTH  : number of issue-queue entries (entry 0 is the oldest)
//   FU_*      : 2-bit functional-unit class encoding carried per entry (3 is reserved)
//   iq_addr_t : entry index as driven on the grant address buses
package iq_pkg;

    localparam int unsigned IQ_DEPTH = 16;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_LS  = 2'd2;

    typedef logic [4:0] iq_addr_t;

endpackage

// File: rtl/iq_find_first.sv
// Lowest-set-bit finder. The lowest index is the oldest entry, so this is an
// oldest-first picker.
// Ports:
//   req   : request vector
//   found : at least one request bit is set
//   idx   : index of the lowest set bit (0 when found is low)
module iq_find_first
    import iq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output iq_addr_t         idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downwards so the last hit wins, leaving the lowest index.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = iq_addr_t'(i);
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Select-and-broadcast side of the 16-entry compacting issue queue.
// Picks the oldest ready entries for ALU0, ALU1, MUL and LS, registers the
// grant/address pairs, and drives the four destination-tag broadcast buses at
// each unit's result latency.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   flush                : pipeline flush (suppresses selection, drops in-flight state)
//   entry_valid/rdy      : per-entry occupied / both sources ready
//   entry_fu             : 2 bits per entry (0 ALU, 1 MUL, 2 LS, 3 reserved)
//   entry_prd            : PRF_WIDTH destination tag per entry
//   ls_ready             : LSU can accept an op this cycle
//   ls_done_valid/tag    : returning load result
//   grant_*/addr_*       : registered issue grants and entry indices
//   tag_bus0..3/tag_vld0..3 : broadcast tags for ALU0, ALU1, MUL, LS
//
// Build option: ISSUE_SPEC_WAKEUP_EN drives the ALU broadcasts combinationally
// from the same-cycle selection (speculative wakeup for back-to-back ALU issue).
// MUL_LAT must lie in 1..7.
module issue_select
    import iq_pkg::*;
#(
    parameter int unsigned PRF_WIDTH = 6,
    parameter int unsigned MUL_LAT   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [IQ_DEPTH-1:0]           entry_valid,
    input  logic [IQ_DEPTH-1:0]           entry_rdy,
    input  logic [2*IQ_DEPTH-1:0]         entry_fu,
    input  logic [IQ_DEPTH*PRF_WIDTH-1:0] entry_prd,
    input  logic                          ls_ready,
    input  logic                          ls_done_valid,
    input  logic [PRF_WIDTH-1:0]          ls_done_tag,
    output logic                          grant_alu0,
    output logic                          grant_alu1,
    output logic                          grant_mul,
    output logic                          grant_ls,
    output iq_addr_t                      addr_alu0,
    output iq_addr_t                      addr_alu1,
    output iq_addr_t                      addr_mul,
    output iq_addr_t                      addr_ls,
    output logic [PRF_WIDTH-1:0]          tag_bus0,
    output logic [PRF_WIDTH-1:0]          tag_bus1,
    output logic [PRF_WIDTH-1:0]          tag_bus2,
    output logic [PRF_WIDTH-1:0]          tag_bus3,
    output logic                          tag_vld0,
    output logic                          tag_vld1,
    output logic                          tag_vld2,
    output logic                          tag_vld3
);

    logic [IQ_DEPTH-1:0]  inflight_q;
    logic [IQ_DEPTH-1:0]  cand;
    logic [IQ_DEPTH-1:0]  alu_mask;
    logic [IQ_DEPTH-1:0]  alu_mask2;
    logic [IQ_DEPTH-1:0]  mul_mask;
    logic [IQ_DEPTH-1:0]  ls_mask;
    logic [IQ_DEPTH-1:0]  sel_onehot;
    logic [PRF_WIDTH-1:0] prd [IQ_DEPTH];

    logic     sel_alu0_vld, sel_alu1_vld, sel_mul_vld, sel_ls_vld;
    iq_addr_t sel_alu0_idx, sel_alu1_idx, sel_mul_idx, sel_ls_idx;
    logic [PRF_WIDTH-1:0] sel_alu0_tag, sel_alu1_tag, sel_mul_tag;

    // Candidate masks. Reset and flush both gate selection so that any
    // combinational consumer of the selection stays quiet in those cycles.
    always_comb begin
        cand     = '0;
        alu_mask = '0;
        mul_mask = '0;
        ls_mask  = '0;
        for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            prd[i]      = entry_prd[i*PRF_WIDTH +: PRF_WIDTH];
            cand[i]     = entry_valid[i] & entry_rdy[i] & ~inflight_q[i] & ~flush & rst_n;
            alu_mask[i] = cand[i] & (entry_fu[2*i +: 2] == FU_ALU);
            mul_mask[i] = cand[i] & (entry_fu[2*i +: 2] == FU_MUL);
            ls_mask[i]  = cand[i] & (entry_fu[2*i +: 2] == FU_LS) & ls_ready;
        end
    end

    // Clearing the lowest set bit leaves the mask for the second-oldest ALU op.
    assign alu_mask2 = alu_mask & (alu_mask - {{(IQ_DEPTH-1){1'b0}}, 1'b1});

    iq_find_first #(.WIDTH(IQ_DEPTH)) u_ff_alu0 (
        .req   (alu_mask),
        .found (sel_alu0_vld),
        .idx   (sel_alu0_idx)
    );

    iq_find_first #(.WIDTH(IQ_DEPTH)) u_ff_alu1 (
        .req   (alu_mask2),
        .found (sel_alu1_vld),
        .idx   (sel_alu1_idx)
    );

    iq_find_first #(.WIDTH(IQ_DEPTH)) u_ff_mul (
        .req   (mul_mask),
        .found (sel_mul_vld),
        .idx   (sel_mul_idx)
    );

    iq_find_first #(.WIDTH(IQ_DEPTH)) u_ff_ls (
        .req   (ls_mask),
        .found (sel_ls_vld),
        .idx   (sel_ls_idx)
    );

    assign sel_alu0_tag = prd[sel_alu0_idx[3:0]];
    assign sel_alu1_tag = prd[sel_alu1_idx[3:0]];
    assign sel_mul_tag  = prd[sel_mul_idx[3:0]];

    always_comb begin
        sel_onehot = '0;
        if (sel_alu0_vld) sel_onehot[sel_alu0_idx[3:0]] = 1'b1;
        if (sel_alu1_vld) sel_onehot[sel_alu1_idx[3:0]] = 1'b1;
        if (sel_mul_vld)  sel_onehot[sel_mul_idx[3:0]]  = 1'b1;
        if (sel_ls_vld)   sel_onehot[sel_ls_idx[3:0]]   = 1'b1;
    end

    // Grant registers and the inflight mask. Selection is already zero under
    // flush, so the plain load clears everything on a flush edge.
    logic     grant_alu0_q, grant_alu1_q, grant_ls_q;
    iq_addr_t addr_alu0_q, addr_alu1_q, addr_mul_q, addr_ls_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q   <= '0;
            grant_alu0_q <= 1'b0;
            grant_alu1_q <= 1'b0;
            grant_ls_q   <= 1'b0;
            addr_alu0_q  <= '0;
            addr_alu1_q  <= '0;
            addr_mul_q   <= '0;
            addr_ls_q    <= '0;
        end else begin
            inflight_q   <= sel_onehot;
            grant_alu0_q <= sel_alu0_vld;
            grant_alu1_q <= sel_alu1_vld;
            grant_ls_q   <= sel_ls_vld;
            addr_alu0_q  <= sel_alu0_vld ? sel_alu0_idx : '0;
            addr_alu1_q  <= sel_alu1_vld ? sel_alu1_idx : '0;
            addr_mul_q   <= sel_mul_vld  ? sel_mul_idx  : '0;
            addr_ls_q    <= sel_ls_vld   ? sel_ls_idx   : '0;
        end
    end

    // MUL pipe: stage 0 is the grant register itself, the remaining MUL_LAT-1
    // stages carry the tag so the last stage lines up with the result.
    // Tags only advance alongside a valid, so the bus holds its last value.
    logic                 mul_vld_q [MUL_LAT];
    logic [PRF_WIDTH-1:0] mul_tag_q [MUL_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(MUL_LAT); k++) begin
                mul_vld_q[k] <= 1'b0;
                mul_tag_q[k] <= '0;
            end
        end else begin
            mul_vld_q[0] <= sel_mul_vld;
            if (sel_mul_vld) mul_tag_q[0] <= sel_mul_tag;
            for (int k = 1; k < int'(MUL_LAT); k++) begin
                mul_vld_q[k] <= mul_vld_q[k-1] & ~flush;
                if (mul_vld_q[k-1] & ~flush) mul_tag_q[k] <= mul_tag_q[k-1];
            end
        end
    end

    // LS broadcast is just a one-cycle register of the returning load.
    logic                 tag_vld3_q;
    logic [PRF_WIDTH-1:0] tag_bus3_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld3_q <= 1'b0;
            tag_bus3_q <= '0;
        end else begin
            tag_vld3_q <= ls_done_valid & ~flush;
            if (ls_done_valid & ~flush) tag_bus3_q <= ls_done_tag;
        end
    end

`ifdef ISSUE_SPEC_WAKEUP_EN
    // Speculative wakeup: broadcast the ALU tags in the selection cycle. The
    // last-value registers only keep the buses stable between broadcasts.
    logic [PRF_WIDTH-1:0] alu0_last_q, alu1_last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu0_last_q <= '0;
            alu1_last_q <= '0;
        end else begin
            if (sel_alu0_vld) alu0_last_q <= sel_alu0_tag;
            if (sel_alu1_vld) alu1_last_q <= sel_alu1_tag;
        end
    end

    assign tag_vld0 = sel_alu0_vld;
    assign tag_vld1 = sel_alu1_vld;
    assign tag_bus0 = sel_alu0_vld ? sel_alu0_tag : alu0_last_q;
    assign tag_bus1 = sel_alu1_vld ? sel_alu1_tag : alu1_last_q;
`else
    // Tags are captured at selection so a compaction after the grant cannot
    // disturb them, then broadcast the cycle after the grant.
    logic [PRF_WIDTH-1:0] alu0_tag_q, alu1_tag_q;
    logic [PRF_WIDTH-1:0] tag_bus0_q, tag_bus1_q;
    logic                 tag_vld0_q, tag_vld1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu0_tag_q <= '0;
            alu1_tag_q <= '0;
            tag_bus0_q <= '0;
            tag_bus1_q <= '0;
            tag_vld0_q <= 1'b0;
            tag_vld1_q <= 1'b0;
        end else begin
            if (sel_alu0_vld) alu0_tag_q <= sel_alu0_tag;
            if (sel_alu1_vld) alu1_tag_q <= sel_alu1_tag;
            tag_vld0_q <= grant_alu0_q & ~flush;
            tag_vld1_q <= grant_alu1_q & ~flush;
            if (grant_alu0_q & ~flush) tag_bus0_q <= alu0_tag_q;
            if (grant_alu1_q & ~flush) tag_bus1_q <= alu1_tag_q;
        end
    end

    assign tag_vld0 = tag_vld0_q;
    assign tag_vld1 = tag_vld1_q;
    assign tag_bus0 = tag_bus0_q;
    assign tag_bus1 = tag_bus1_q;
`endif

    assign grant_alu0 = grant_alu0_q;
    assign grant_alu1 = grant_alu1_q;
    assign grant_mul  = mul_vld_q[0];
    assign grant_ls   = grant_ls_q;
    assign addr_alu0  = addr_alu0_q;
    assign addr_alu1  = addr_alu1_q;
    assign addr_mul   = addr_mul_q;
    assign addr_ls    = addr_ls_q;
    assign tag_vld2   = mul_vld_q[MUL_LAT-1];
    assign tag_bus2   = mul_tag_q[MUL_LAT-1];
    assign tag_vld3   = tag_vld3_q;
    assign tag_bus3   = tag_bus3_q;

endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: stimulus pushes expected (channel, cycle,
// value) records; a negedge monitor pops and compares whenever an output is valid.
// Channels: 0..3 = grant ALU0/ALU1/MUL/LS (value = addr), 4..7 = tag_vld0..3 (value = tag).
module tb_issue_select;

    localparam int PRF_WIDTH = 6;
    localparam int MUL_LAT   = 3;
`ifdef ISSUE_SPEC_WAKEUP_EN
    localparam int ALU_TAG_LAT = 0;
`else
    localparam int ALU_TAG_LAT = 2;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n, flush, ls_ready, ls_done_valid;
    logic [15:0]             entry_valid, entry_rdy;
    logic [31:0]             entry_fu;
    logic [16*PRF_WIDTH-1:0] entry_prd;
    logic [PRF_WIDTH-1:0]    ls_done_tag;
    logic                    grant_alu0, grant_alu1, grant_mul, grant_ls;
    logic [4:0]              addr_alu0, addr_alu1, addr_mul, addr_ls;
    logic [PRF_WIDTH-1:0]    tag_bus0, tag_bus1, tag_bus2, tag_bus3;
    logic                    tag_vld0, tag_vld1, tag_vld2, tag_vld3;

    issue_select #(.PRF_WIDTH(PRF_WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .entry_valid   (entry_valid),
        .entry_rdy     (entry_rdy),
        .entry_fu      (entry_fu),
        .entry_prd     (entry_prd),
        .ls_ready      (ls_ready),
        .ls_done_valid (ls_done_valid),
        .ls_done_tag   (ls_done_tag),
        .grant_alu0    (grant_alu0),
        .grant_alu1    (grant_alu1),
        .grant_mul     (grant_mul),
        .grant_ls      (grant_ls),
        .addr_alu0     (addr_alu0),
        .addr_alu1     (addr_alu1),
        .addr_mul      (addr_mul),
        .addr_ls       (addr_ls),
        .tag_bus0      (tag_bus0),
        .tag_bus1      (tag_bus1),
        .tag_bus2      (tag_bus2),
        .tag_bus3      (tag_bus3),
        .tag_vld0      (tag_vld0),
        .tag_vld1      (tag_vld1),
        .tag_vld2      (tag_vld2),
        .tag_vld3      (tag_vld3)
    );

    typedef struct {
        int ch;
        int cyc;
        int val;
    } exp_t;

    exp_t  sbq[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    mon_en   = 1'b0;
    string ch_name [8];
    bit    mv [8];
    int    mval [8];
    int    mon_k;
    int    mon_i;
    int    t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic put(input int idx, input int fu, input int prd);
        entry_valid[idx] = 1'b1;
        entry_rdy[idx]   = 1'b1;
        entry_fu[2*idx +: 2] = fu[1:0];
        entry_prd[idx*PRF_WIDTH +: PRF_WIDTH] = prd[PRF_WIDTH-1:0];
    endtask

    task automatic drop(input int idx);
        entry_valid[idx] = 1'b0;
        entry_rdy[idx]   = 1'b0;
    endtask

    task automatic clear_all();
        entry_valid = '0;
        entry_rdy   = '0;
    endtask

    task automatic expect_out(input int ch, input int c, input int v);
        exp_t e;
        e.ch  = ch;
        e.cyc = c;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        check({name, " grants"}, int'({grant_alu0, grant_alu1, grant_mul, grant_ls}), 0);
        check({name, " addrs"}, int'({addr_alu0, addr_alu1, addr_mul, addr_ls}), 0);
        check({name, " tag_vld"}, int'({tag_vld0, tag_vld1, tag_vld2, tag_vld3}), 0);
        check({name, " tag_bus"}, int'({tag_bus0, tag_bus1, tag_bus2, tag_bus3}), 0);
    endtask

    // Monitor: every valid output must match the oldest pending record of its
    // channel; idle grants must show address 0; overdue records are misses.
    always @(negedge clk) begin
        if (mon_en) begin
            mv[0] = grant_alu0; mval[0] = int'(addr_alu0);
            mv[1] = grant_alu1; mval[1] = int'(addr_alu1);
            mv[2] = grant_mul;  mval[2] = int'(addr_mul);
            mv[3] = grant_ls;   mval[3] = int'(addr_ls);
            mv[4] = tag_vld0;   mval[4] = int'(tag_bus0);
            mv[5] = tag_vld1;   mval[5] = int'(tag_bus1);
            mv[6] = tag_vld2;   mval[6] = int'(tag_bus2);
            mv[7] = tag_vld3;   mval[7] = int'(tag_bus3);
            for (int ch = 0; ch < 8; ch++) begin
                if (mv[ch]) begin
                    mon_k = -1;
                    for (int i = 0; i < sbq.size(); i++)
                        if (mon_k < 0 && sbq[i].ch == ch) mon_k = i;
                    if (mon_k < 0) begin
                        checks++;
                        failures++;
                        $display("FAIL %s unexpected at cycle %0d: got valid with %0h, required idle",
                                 ch_name[ch], cyc, mval[ch]);
                    end else begin
                        check({ch_name[ch], " cycle"}, cyc, sbq[mon_k].cyc);
                        check({ch_name[ch], " value"}, mval[ch], sbq[mon_k].val);
                        sbq.delete(mon_k);
                    end
                end else if (ch < 4) begin
                    check({ch_name[ch], " idle addr"}, mval[ch], 0);
                end
            end
            mon_i = 0;
            while (mon_i < sbq.size()) begin
                if (sbq[mon_i].cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s missing: got nothing at cycle %0d, required %0h",
                             ch_name[sbq[mon_i].ch], sbq[mon_i].cyc, sbq[mon_i].val);
                    sbq.delete(mon_i);
                end else begin
                    mon_i++;
                end
            end
        end
    end

    initial begin
        ch_name[0] = "grant_alu0"; ch_name[1] = "grant_alu1";
        ch_name[2] = "grant_mul";  ch_name[3] = "grant_ls";
        ch_name[4] = "tag_vld0";   ch_name[5] = "tag_vld1";
        ch_name[6] = "tag_vld2";   ch_name[7] = "tag_vld3";

        rst_n = 1'b0; flush = 1'b0; ls_ready = 1'b0;
        ls_done_valid = 1'b0; ls_done_tag = '0;
        entry_valid = '0; entry_rdy = '0; entry_fu = '0; entry_prd = '0;

        // Reset held with every entry ready: outputs stay zero.
        for (int i = 0; i < 16; i++) put(i, 0, 'h30 + i);
        step();
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_zero("reset hold");
            step();
        end
        // Release: oldest two ALU entries granted the next cycle.
        rst_n = 1'b0 | 1'b1;
        t = cyc;
        expect_out(0, t + 1, 0);
        expect_out(1, t + 1, 1);
        expect_out(4, t + ALU_TAG_LAT, 'h30);
        expect_out(5, t + ALU_TAG_LAT, 'h31);
        step();
        clear_all();
        idle(3);

        // ALU pair 3/5 first, then 9 while 3/5 are inflight.
        put(3, 0, 'h13); put(5, 0, 'h15); put(9, 0, 'h19);
        t = cyc;
        expect_out(0, t + 1, 3);
        expect_out(1, t + 1, 5);
        expect_out(4, t + ALU_TAG_LAT, 'h13);
        expect_out(5, t + ALU_TAG_LAT, 'h15);
        expect_out(0, t + 2, 9);
        expect_out(4, t + 1 + ALU_TAG_LAT, 'h19);
        step(); step();
        drop(3); drop(5);
        step();
        drop(9);
        idle(3);
        check("alu0 tag hold", int'(tag_bus0), 'h19);
        check("alu1 tag hold", int'(tag_bus1), 'h15);

        // Inflight masking: entry 2 valid two cycles, one grant.
        put(2, 0, 'h22);
        t = cyc;
        expect_out(0, t + 1, 2);
        expect_out(4, t + ALU_TAG_LAT, 'h22);
        step(); step();
        drop(2);
        idle(3);

        // Back-to-back MUL grants and broadcasts.
        put(4, 1, 'h2A); put(6, 1, 'h2B);
        t = cyc;
        expect_out(2, t + 1, 4);
        expect_out(2, t + 2, 6);
        expect_out(6, t + MUL_LAT, 'h2A);
        expect_out(6, t + 1 + MUL_LAT, 'h2B);
        step(); step();
        drop(4);
        step();
        drop(6);
        idle(4);

        // LS gated by ls_ready, then a load return.
        put(7, 2, 'h07);
        ls_ready = 1'b0;
        idle(3);
        ls_ready = 1'b1;
        t = cyc;
        expect_out(3, t + 1, 7);
        step(); step();
        drop(7);
        ls_ready = 1'b0;
        ls_done_valid = 1'b1; ls_done_tag = 'h11;
        t = cyc;
        expect_out(7, t + 1, 'h11);
        step();
        ls_done_valid = 1'b0;
        idle(2);
        check("ls tag hold", int'(tag_bus3), 'h11);

        // Flush one cycle after a MUL grant: broadcast and ls_done dropped,
        // selection suppressed in the flush cycle.
        put(4, 1, 'h2C);
        t = cyc;
        expect_out(2, t + 1, 4);
        step();
        flush = 1'b1;
        put(1, 0, 'h31);
        ls_done_valid = 1'b1; ls_done_tag = 'h22;
        step();
        flush = 1'b0;
        ls_done_valid = 1'b0;
        clear_all();
        idle(4);
        check("flush ls_done dropped", int'(tag_bus3), 'h11);
        check("flush mul tag kept", int'(tag_bus2), 'h2B);

        // All 16 ALU entries ready: 0 and 1 win.
        for (int i = 0; i < 16; i++) put(i, 0, 'h20 + i);
        t = cyc;
        expect_out(0, t + 1, 0);
        expect_out(1, t + 1, 1);
        expect_out(4, t + ALU_TAG_LAT, 'h20);
        expect_out(5, t + ALU_TAG_LAT, 'h21);
        step();
        clear_all();
        idle(3);

        // All 16 ready, mixed classes (i % 4), reserved class never picked.
        for (int i = 0; i < 16; i++) put(i, i % 4, 'h20 + i);
        ls_ready = 1'b1;
        t = cyc;
        expect_out(0, t + 1, 0);
        expect_out(1, t + 1, 4);
        expect_out(2, t + 1, 1);
        expect_out(3, t + 1, 2);
        expect_out(4, t + ALU_TAG_LAT, 'h20);
        expect_out(5, t + ALU_TAG_LAT, 'h24);
        expect_out(6, t + MUL_LAT, 'h21);
        step();
        clear_all();
        ls_ready = 1'b0;
        idle(4);

        // Reserved entry ignored and a single ALU candidate: no ALU1 grant.
        put(0, 3, 'h3F); put(8, 0, 'h28);
        t = cyc;
        expect_out(0, t + 1, 8);
        expect_out(4, t + ALU_TAG_LAT, 'h28);
        step();
        clear_all();
        idle(3);

        // Occupied but nothing ready: no grants.
        entry_valid = '1;
        entry_rdy   = '0;
        idle(2);
        clear_all();

        // Reset mid-MUL discards the pending broadcast.
        put(5, 1, 'h35);
        t = cyc;
        expect_out(2, t + 1, 5);
        step();
        rst_n = 1'b0;
        clear_all();
        step();
        rst_n = 1'b1;
        chk_zero("reset mid mul");
        idle(4);

        check("scoreboard drained", sbq.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Select-and-broadcast side of the 16-entry compacting issue queue.
- Picks the oldest ready entries for the four issue ports (ALU0, ALU1, MUL, LS) and drives registered grant/address pairs.
- Drives the four destination-tag broadcast buses at each functional unit's result latency; the per-entry wakeup comparators consume these buses.
- Entry 0 is the oldest entry, so a lower index always means older.

Parameters:
- PRF_WIDTH, 6, physical register tag width.
- IQ_DEPTH, 16, issue queue entries; fixed at 16 because addresses are 5 bits.
- MUL_LAT, 3, multiplier result latency in cycles (allowed range 1..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush
- entry_valid  in  16  entry occupied
- entry_rdy  in  16  both sources of the entry are ready
- entry_fu  in  32  2 bits per entry: 0=ALU, 1=MUL, 2=LS, 3=reserved (never selected)
- entry_prd  in  16*PRF_WIDTH  destination tag of each entry
- ls_ready  in  1  LSU can accept an op this cycle
- ls_done_valid  in  1  load result returning
- ls_done_tag  in  PRF_WIDTH  tag of the returning load
- grant_alu0, grant_alu1, grant_mul, grant_ls  out  1 each  issue grants
- addr_alu0, addr_alu1, addr_mul, addr_ls  out  5 each  granted entry index
- tag_bus0..tag_bus3  out  PRF_WIDTH each  broadcast tags (ALU0, ALU1, MUL, LS)
- tag_vld0..tag_vld3  out  1 each  broadcast tag is valid

Behaviour:
- Candidate set: cand[i] = entry_valid[i] & entry_rdy[i] & ~inflight[i].
- inflight is a 16-bit register holding the entries granted in the previous cycle; the queue deallocates an entry one cycle after seeing its grant.
- Selection (combinational, from cand):
  - ALU0 takes the lowest-index ALU candidate.
  - ALU1 takes the second-lowest ALU candidate.
  - MUL takes the lowest MUL candidate.
  - LS takes the lowest LS candidate, only when ls_ready=1.
- Grants and addresses are registered, so a grant appears one cycle after the entry is a candidate. When a grant is low, its address holds 0.
- inflight is loaded next cycle with the one-hot OR of all selections made this cycle.
- ALU tag broadcast: tag_bus0/1 = entry_prd of the granted entry, registered one cycle after the grant. tag_vld follows the grant one cycle later.
- MUL tag broadcast:
  - A MUL_LAT-1 stage shift register carries {valid, tag} from the grant cycle.
  - tag_vld2 asserts exactly MUL_LAT cycles after the selection cycle.
  - The multiplier is fully pipelined: one grant per cycle, no stall.
- LS tag broadcast: tag_bus3/tag_vld3 register ls_done_tag/ls_done_valid with one cycle latency, independent of grant_ls.
- When a tag bus is not valid, it holds its last value; consumers must qualify with tag_vld.
- Reset (rst_n=0 at a clock edge), for all of grants, addresses, tag_bus*, tag_vld*, inflight and the MUL pipe:
  - Every grant and tag_vld = 0.
  - Every address and tag bus = 0.
  - inflight = 0.
- Flush, next edge:
  - Grants, inflight, MUL pipe valids and ALU tag_vld clear.
  - tag_vld3 clears; a concurrent ls_done is dropped.
  - Selection is suppressed during the flush cycle.
- Boundaries:
  - Fewer than two ALU candidates: grant_alu1=0.
  - Zero candidates: all grants 0.
  - All 16 entries ready: entries 0 and 1 go to the ALUs.
  - entry_fu=3 is ignored.
  - Reset mid-MUL: pending broadcasts are discarded.

Optional Feature:
- Macro: ISSUE_SPEC_WAKEUP_EN
- Defined: ALU tag_bus0/1 and tag_vld0/1 are driven combinationally from the selection in the same cycle, one cycle before the grant. This enables back-to-back dependent ALU issue. Flush gates them combinationally.
- Undefined: the registered behaviour described above.
- MUL and LS behaviour is unchanged in both cases.

Decomposition:
- Shared package iq_pkg:
  - FU encoding constants FU_ALU=2'd0, FU_MUL=2'd1, FU_LS=2'd2.
  - IQ_DEPTH.
  - typedef iq_addr_t = logic [4:0].
- One sub-module, iq_find_first: parameterised lowest-set-bit finder over 16 bits, returning a valid flag and a 5-bit index.
  - Instantiated for ALU-first, ALU-second (on the mask with the first bit cleared), MUL and LS.

Test Plan:
- ALU0/ALU1 selection: entries 3,5,9 ALU ready -> next cycle grant_alu0=1 addr_alu0=3, grant_alu1=1 addr_alu1=5. Entry 9 is granted the cycle after, while 3/5 are masked by inflight.
- Inflight masking: entry 2 ALU ready and still valid for two cycles -> exactly one grant for entry 2.
- MUL latency: MUL entry 4 with prd=6'h2A selected at cycle t -> tag_vld2=1, tag_bus2=2A at t+3, and only that cycle. Back-to-back MUL grants produce back-to-back broadcasts.
- LS ready gating: LS entry 7 ready, ls_ready=0 for 3 cycles then 1 -> grant_ls only after ls_ready=1, with addr_ls=7. ls_done_valid with tag=0x11 -> tag_vld3/tag_bus3=0x11 one cycle later.
- Flush mid-MUL: MUL grant at t, flush at t+1 -> no tag_vld2 at t+3, and all grants 0 at t+2.
- Reset: rst_n=0 with all entries ready -> all outputs 0 while reset is held. The first grants appear the cycle after release. With ISSUE_SPEC_WAKEUP_EN defined, tag_vld0 accompanies the selection one cycle before grant_alu0.
